// File: rtl/i8251_pkg.sv
// i8251 host bus initiator: shared status/command constants
// and the state types used by the host and its bus sequencer.
package i8251_pkg;

    localparam int ST_TXRDY = 0;
    localparam int ST_RXRDY = 1;
    localparam int ST_PE    = 3;
    localparam int ST_OE    = 4;
    localparam int ST_FE    = 5;

    localparam logic [7:0] CMD_ER = 8'h10;
    localparam logic [7:0] CMD_IR = 8'h40;

    typedef enum logic [2:0] {
        INIT,
        POLL,
        DECIDE,
        RDDATA,
        WRDATA,
        ERRCLR
    } host_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_RECOVER
    } bus_phase_t;

endpackage

// File: rtl/i8251_bus_cycle.sv
// One i8251 port access: SETUP, ACC_TICKS of STROBE, RECOVER.
// A new start is taken during the RECOVER tick so accesses chain.
module i8251_bus_cycle
    import i8251_pkg::*;
#(
    parameter int ACC_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic       start,
    input  logic       is_write,
    input  logic       c_d_sel,
    input  logic [7:0] wdata,
    input  logic [7:0] bus_din,
    output logic       accepted,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       c_d,
    output logic [7:0] bus_dout
);

    localparam int CW = (ACC_TICKS > 1) ? $clog2(ACC_TICKS) : 1;

    bus_phase_t    phase, phase_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          load, sample;
    logic          wr_q, cd_q;
    logic [7:0]    dout_q, rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= PH_IDLE;
            cnt   <= '0;
        end else begin
            phase <= phase_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase;
        cnt_d   = cnt;
        load    = 1'b0;
        sample  = 1'b0;
        unique case (phase)
            PH_IDLE: begin
                if (clken && start) begin
                    phase_d = PH_SETUP;
                    load    = 1'b1;
                end
            end
            PH_SETUP: begin
                if (clken) begin
                    phase_d = PH_STROBE;
                    cnt_d   = CW'(ACC_TICKS - 1);
                end
            end
            PH_STROBE: begin
                if (clken) begin
                    if (cnt == '0) begin
                        phase_d = PH_RECOVER;
                        sample  = !wr_q;
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
            end
            PH_RECOVER: begin
                if (clken) begin
                    load    = start;
                    phase_d = start ? PH_SETUP : PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            cd_q    <= 1'b1;
            dout_q  <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            if (load) begin
                wr_q   <= is_write;
                cd_q   <= c_d_sel;
                dout_q <= wdata;
            end
            if (sample) begin
                rdata_q <= bus_din;
            end
        end
    end

    // Strobes decode straight from the phase so reset drops them at once
    assign cs_n     = !(phase == PH_SETUP || phase == PH_STROBE);
    assign rd_n     = !(phase == PH_STROBE && !wr_q);
    assign wr_n     = !(phase == PH_STROBE && wr_q);
    assign c_d      = cd_q;
    assign bus_dout = dout_q;
    assign rdata    = rdata_q;
    assign accepted = load;
    assign done     = clken && (phase == PH_RECOVER);

endmodule

// File: rtl/i8251_host.sv
// CPU-side i8251 driver: init sequence, then status polling that
// moves bytes between the UART and the TX/RX byte streams.
module i8251_host
    import i8251_pkg::*;
#(
    parameter logic [7:0] MODE_WORD = 8'h4E,
    parameter logic [7:0] CMD_WORD  = 8'h37,
    parameter int         ACC_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic       reinit,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       c_d,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       init_done,
    output logic [2:0] err_flags
);

    host_state_t state, state_d;
    logic        launched, launched_d;
    logic [2:0]  init_idx, op_idx;
    logic        pend, pend_eff;
    logic        st_tx, st_rx;
    logic [2:0]  st_err;
    logic [7:0]  tx_q;

    logic        start, chain, accepted, done, acc_done, acc_state;
    logic        bc_write, bc_cd;
    logic [7:0]  bc_wdata, rdata;
    logic        restart, idx_inc, set_done, err_set;
    logic        cap_status, rx_load, tx_latch;
    logic        dec_err, dec_rx, dec_tx;

    function automatic logic [7:0] init_word(input logic [2:0] idx);
        case (idx)
            3'd3:    return CMD_IR;
            3'd4:    return MODE_WORD;
            3'd5:    return CMD_WORD;
            default: return 8'h00;
        endcase
    endfunction

    assign pend_eff  = pend | reinit;
    assign acc_state = (state != DECIDE);
    assign acc_done  = launched && done;
    // Init writes chain straight out of RECOVER with no idle tick
    assign chain     = acc_done && (state == INIT) && !pend_eff &&
                       (init_idx != 3'd5);
    assign start     = (acc_state && !launched) || chain;
    assign op_idx    = chain ? init_idx + 3'd1 : init_idx;

    assign dec_err = |st_err;
    assign dec_rx  = !dec_err && st_rx && !rx_valid;
    assign dec_tx  = !dec_err && !dec_rx && st_tx;

    always_comb begin
        bc_write = 1'b1;
        bc_cd    = 1'b1;
        bc_wdata = init_word(op_idx);
        unique case (state)
            POLL:    bc_write = 1'b0;
            RDDATA: begin
                bc_write = 1'b0;
                bc_cd    = 1'b0;
            end
            WRDATA: begin
                bc_cd    = 1'b0;
                bc_wdata = tx_q;
            end
            ERRCLR:  bc_wdata = CMD_WORD | CMD_ER;
            default: bc_write = 1'b1;
        endcase
    end

    i8251_bus_cycle #(
        .ACC_TICKS(ACC_TICKS)
    ) u_bus (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .start    (start),
        .is_write (bc_write),
        .c_d_sel  (bc_cd),
        .wdata    (bc_wdata),
        .bus_din  (bus_din),
        .accepted (accepted),
        .done     (done),
        .rdata    (rdata),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .c_d      (c_d),
        .bus_dout (bus_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            launched <= 1'b0;
        end else begin
            state    <= state_d;
            launched <= launched_d;
        end
    end

    always_comb begin
        state_d    = state;
        launched_d = launched;
        restart    = 1'b0;
        idx_inc    = 1'b0;
        set_done   = 1'b0;
        err_set    = 1'b0;
        cap_status = 1'b0;
        rx_load    = 1'b0;
        tx_latch   = 1'b0;
        tx_ready   = 1'b0;
        if (acc_done) launched_d = 1'b0;
        if (accepted) launched_d = 1'b1;
        unique case (state)
            INIT: begin
                if (acc_done) begin
                    if (pend_eff) begin
                        restart = 1'b1;
                    end else if (init_idx == 3'd5) begin
                        set_done = 1'b1;
                        state_d  = POLL;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            POLL: begin
                if (acc_done) begin
                    cap_status = 1'b1;
                    state_d    = DECIDE;
                    restart    = pend_eff;
                end
            end
            DECIDE: begin
                if (pend_eff) begin
                    restart = 1'b1;
                end else begin
                    unique case (1'b1)
                        dec_err: begin
                            err_set = 1'b1;
                            state_d = ERRCLR;
                        end
                        dec_rx: state_d = RDDATA;
                        dec_tx: begin
                            tx_ready = 1'b1;
                            tx_latch = tx_valid;
                            state_d  = tx_valid ? WRDATA : POLL;
                        end
                        default: state_d = POLL;
                    endcase
                end
            end
            RDDATA: begin
                if (acc_done) begin
                    rx_load = 1'b1;
                    state_d = POLL;
                    restart = pend_eff;
                end
            end
            WRDATA, ERRCLR: begin
                if (acc_done) begin
                    state_d = POLL;
                    restart = pend_eff;
                end
            end
            default: state_d = INIT;
        endcase
        if (restart) state_d = INIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_idx  <= 3'd0;
            pend      <= 1'b0;
            init_done <= 1'b0;
            err_flags <= 3'b000;
            st_tx     <= 1'b0;
            st_rx     <= 1'b0;
            st_err    <= 3'b000;
            tx_q      <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            if (restart) begin
                init_idx  <= 3'd0;
                pend      <= 1'b0;
                init_done <= 1'b0;
                err_flags <= 3'b000;
            end else begin
                if (reinit)   pend      <= 1'b1;
                if (idx_inc)  init_idx  <= init_idx + 3'd1;
                if (set_done) init_done <= 1'b1;
                if (err_set)  err_flags <= err_flags | st_err;
            end
            if (cap_status) begin
                st_tx  <= rdata[ST_TXRDY];
                st_rx  <= rdata[ST_RXRDY];
                st_err <= {rdata[ST_FE], rdata[ST_OE], rdata[ST_PE]};
            end
            if (tx_latch) tx_q <= tx_data;
            if (rx_load) begin
                rx_data  <= rdata;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i8251_host.sv
// Bench for i8251_host against a behavioural i8251 in tx->rx loopback.
// Randomized bytes are checked against an in-order/overwrite reference.
module tb_i8251_host;

    localparam int A     = 2;
    localparam int FRAME = 40;

    logic       clk = 1'b0;
    logic       reset, clken, reinit;
    logic [7:0] bus_din, bus_dout;
    logic       cs_n, rd_n, wr_n, c_d;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       init_done;
    logic [2:0] err_flags;

    always #5 clk = ~clk;

    i8251_host #(
        .MODE_WORD(8'h4E),
        .CMD_WORD (8'h37),
        .ACC_TICKS(A)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .reinit   (reinit),
        .bus_din  (bus_din),
        .bus_dout (bus_dout),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .c_d      (c_d),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .init_done(init_done),
        .err_flags(err_flags)
    );

    // clken: every div-th clk
    int div = 1;
    int ccnt = 0;
    always @(negedge clk) begin
        ccnt  = (ccnt + 1) % div;
        clken = (ccnt == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rnd_rx, rnd_bit, rdy_set;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign rx_ready = rnd_rx ? rnd_bit : rdy_set;

    // Behavioural i8251 with the transmitter looped into the receiver
    logic       m_rxrdy = 1'b0;
    logic       m_oe = 1'b0, m_pe = 1'b0, m_fe = 1'b0;
    logic       m_mode_next = 1'b0;
    logic [7:0] m_rxbuf = 8'h00, m_tx_byte = 8'h00;
    int         m_tx_timer = 0;
    logic       inj_fe;

    assign bus_din = c_d ? {2'b00, m_fe, m_oe, m_pe, 1'b0, m_rxrdy,
                            (m_tx_timer == 0)}
                         : m_rxbuf;

    logic [7:0] ctl_wr[$];
    logic [7:0] data_wr[$];
    logic [7:0] rx_got[$];
    int         wr_w = 0, last_wr_w = 0, data_w = 0, bad_txr = 0;
    logic       prev_wr = 1'b1, prev_rd = 1'b1;

    always @(negedge clk) begin
        if (!wr_n) wr_w++;
        if (wr_n && !prev_wr) begin
            last_wr_w = wr_w;
            if (c_d) begin
                ctl_wr.push_back(bus_dout);
                if (m_mode_next) begin
                    m_mode_next = 1'b0;
                end else if (bus_dout[6]) begin
                    m_mode_next = 1'b1;
                    m_rxrdy = 1'b0;
                    {m_oe, m_pe, m_fe} = 3'b000;
                    m_tx_timer = 0;
                end else if (bus_dout[4]) begin
                    {m_oe, m_pe, m_fe} = 3'b000;
                end
            end else begin
                data_wr.push_back(bus_dout);
                data_w = wr_w;
                m_tx_byte = bus_dout;
                m_tx_timer = FRAME;
            end
            wr_w = 0;
        end
        if (rd_n && !prev_rd && !c_d) m_rxrdy = 1'b0;
        if (m_tx_timer > 0) begin
            m_tx_timer--;
            if (m_tx_timer == 0) begin
                if (m_rxrdy) m_oe = 1'b1;
                m_rxbuf = m_tx_byte;
                m_rxrdy = 1'b1;
            end
        end
        if (inj_fe) m_fe = 1'b1;
        if (rx_valid && rx_ready) rx_got.push_back(rx_data);
        if (tx_ready && !init_done) bad_txr++;
        prev_wr = wr_n;
        prev_rd = rd_n;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !tx_ready; i++) tick();
        chk("tx_handshake", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 6000 && rx_got.size() < n; i++) tick();
        chk("rx_count", rx_got.size(), n);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 1000 && !init_done; i++) tick();
        chk("init_done", 32'(init_done), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, 32'({cs_n, rd_n, wr_n, c_d, bus_dout, tx_ready,
                      rx_valid, rx_data, init_done, err_flags}),
            32'({4'b1111, 22'd0}));
    endtask

    task automatic chk_init_seq(input string tag, input int base);
        logic [7:0] seq[6];
        seq = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h4E, 8'h37};
        chk({tag, "_n"}, 32'(ctl_wr.size() >= base + 6), 32'd1);
        for (int k = 0; k < 6 && base + k < ctl_wr.size(); k++)
            chk($sformatf("%s_w%0d", tag, k), 32'(ctl_wr[base+k]),
                32'(seq[k]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, nd0, nc0, rg0, found;
        logic [7:0] b1, b2, b3, b;
        logic [7:0] exp_q[$];

        reset = 1'b1; reinit = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        rdy_set = 1'b0; rnd_rx = 1'b0; inj_fe = 1'b0;
        repeat (3) tick();
        chk_reset_outs("reset_vals");

        // 1: init sequence and its length
        reset = 1'b0;
        for (int i = 0; i < 50 && cs_n; i++) tick();
        chk("setup_seen", 32'(cs_n), 32'd0);
        t0 = cyc;
        wait_init();
        chk("init_ticks", cyc - t0, 6 * (A + 2));
        tick();
        chk_init_seq("init", 0);
        chk("init_wr_width", last_wr_w, A);
        chk("init_no_data", data_wr.size(), 0);

        // 2: single loopback byte
        rdy_set = 1'b1;
        nd0 = data_wr.size();
        rg0 = rx_got.size();
        send(8'hA5);
        wait_rx(rg0 + 1);
        chk("t2_rx", 32'(rx_got[rg0]), 32'hA5);
        chk("t2_nwr", data_wr.size() - nd0, 1);
        chk("t2_wr", 32'(data_wr[nd0]), 32'hA5);
        chk("t2_err", 32'(err_flags), 32'd0);

        // 3: overrun while the consumer stalls
        rdy_set = 1'b0;
        rg0 = rx_got.size();
        nc0 = ctl_wr.size();
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        send(b1);
        send(b2);
        send(b3);
        for (int i = 0; i < 3000 && !err_flags[1]; i++) tick();
        repeat (30) tick();
        chk("t3_err", 32'(err_flags), 32'b010);
        chk("t3_rxv", 32'(rx_valid), 32'd1);
        chk("t3_rxd", 32'(rx_data), 32'(b1));
        found = 0;
        for (int k = nc0; k < ctl_wr.size(); k++)
            if (ctl_wr[k] == 8'h37) found = 1;
        chk("t3_errclr", found, 1);
        inj_fe = 1'b1;
        tick();
        inj_fe = 1'b0;
        for (int i = 0; i < 500 && !err_flags[2]; i++) tick();
        chk("t3_fe", 32'(err_flags), 32'b110);
        rdy_set = 1'b1;
        wait_rx(rg0 + 2);
        chk("t3_first", 32'(rx_got[rg0]), 32'(b1));
        chk("t3_newest", 32'(rx_got[rg0+1]), 32'(b3));

        // random stream with a random consumer
        rnd_rx = 1'b1;
        rg0 = rx_got.size();
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b);
            repeat ($urandom_range(0, 30)) tick();
        end
        wait_rx(rg0 + 6);
        for (int n = 0; n < 6 && rg0 + n < rx_got.size(); n++)
            chk($sformatf("rnd_rx%0d", n), 32'(rx_got[rg0+n]),
                32'(exp_q[n]));
        rnd_rx = 1'b0;

        // 4: slow bus timing
        div = 4;
        repeat (8) tick();
        rg0 = rx_got.size();
        b = 8'($urandom);
        send(b);
        wait_rx(rg0 + 1);
        chk("t4_rx", 32'(rx_got[rg0]), 32'(b));
        chk("t4_wr_width", data_w, A * 4);
        div = 1;
        repeat (8) tick();

        // 5: reinit during a data write strobe
        send(8'h3C);
        for (int i = 0; i < 40 && !(!wr_n && !c_d); i++) tick();
        chk("t5_strobe", 32'({wr_n, c_d}), 32'd0);
        nc0 = ctl_wr.size();
        nd0 = data_wr.size();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        for (int i = 0; i < 40 && !wr_n; i++) tick();
        tick();
        tick();
        chk("t5_wr_width", data_w, A);
        chk("t5_nwr", data_wr.size() - nd0, 1);
        chk("t5_done_drop", 32'(init_done), 32'd0);
        chk("t5_err_clr", 32'(err_flags), 32'd0);
        wait_init();
        tick();
        chk_init_seq("t5_init", nc0);

        // 6: async reset in the middle of a strobe
        for (int i = 0; i < 200 && rd_n; i++) tick();
        chk("t6_strobe", 32'(rd_n), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outs("t6_reset_vals");
        tick();
        reset = 1'b0;
        wait_init();

        chk("txr_in_init", bad_txr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
